// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with glitch-filtered start detection, parity/framing checks
// and a valid/ready output holding register with overrun reporting.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] CntMid  = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
    localparam logic            StopLast = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   frame_done;
    logic                   frame_fe;

    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
        end
    end

    // Next-state logic; everything here advances only on tick
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        fe_d       = fe_q;
        pe_d       = pe_q;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        cnt_d   = '0;
                        fe_d    = 1'b0;
                        pe_d    = 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntMid) begin
                        cnt_d   = '0;
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntMax) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (idx_q == IdxLast) begin
                            idx_d   = '0;
                            state_d = (PARITY_MODE != 0) ? StParity : StStop;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt_q == CntMax) begin
                        cnt_d   = '0;
                        pe_d    = (PARITY_MODE == 2) ? ~(^shreg_q ^ rx_s) : (^shreg_q ^ rx_s);
                        state_d = StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntMax) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            fe_d = 1'b1;
                        end
                        // Leave at the last stop midpoint so an early next start is caught
                        if (stop_idx_q == StopLast) begin
                            stop_idx_d = 1'b0;
                            state_d    = StIdle;
                        end else begin
                            stop_idx_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = tick && (state_q == StStop) && (cnt_q == CntMax) &&
                     (stop_idx_q == StopLast);
        frame_fe   = fe_q | ~rx_s;
    end

    always_comb begin
        dout_d       = dout_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (dout_ready) begin
            valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!valid_q || dout_ready) begin
                dout_d       = shreg_q;
                frame_err_d  = frame_fe;
                parity_err_d = pe_q;
                valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 8O2) driven by directed frames.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] rx_v = 3'b111;
    logic [2:0] ready_v = 3'b111;
    logic [7:0] dout_w [3];
    logic [2:0] valid_w, fe_w, pe_w, ovr_w, busy_w;

    exp_t exp_q [3][$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_total = 0;
    int   ovr_total = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1),
                  .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .tick(tick), .dout(dout_w[0]),
        .dout_valid(valid_w[0]), .dout_ready(ready_v[0]), .frame_err(fe_w[0]),
        .parity_err(pe_w[0]), .overrun(ovr_w[0]), .busy(busy_w[0]));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1),
                  .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .tick(tick), .dout(dout_w[1]),
        .dout_valid(valid_w[1]), .dout_ready(ready_v[1]), .frame_err(fe_w[1]),
        .parity_err(pe_w[1]), .overrun(ovr_w[1]), .busy(busy_w[1]));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(2),
                  .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .tick(tick), .dout(dout_w[2]),
        .dout_valid(valid_w[2]), .dout_ready(ready_v[2]), .frame_err(fe_w[2]),
        .parity_err(pe_w[2]), .overrun(ovr_w[2]), .busy(busy_w[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Advance n baud ticks, then settle 1ns past the edge before driving
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic expect_frame(input int ch, input logic [7:0] d, input logic fe,
                                input logic pe);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        exp_q[ch].push_back(e);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] data, input logic has_par,
                              input logic par_bit, input int nstop, input logic [1:0] stops);
        rx_v[ch] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_v[ch] = data[i];
            wait_ticks(16);
        end
        if (has_par) begin
            rx_v[ch] = par_bit;
            wait_ticks(16);
        end
        for (int i = 0; i < nstop; i++) begin
            rx_v[ch] = stops[i];
            wait_ticks(16);
        end
        rx_v[ch] = 1'b1;
    endtask

    task automatic wait_drain(input int ch);
        int n = 0;
        while (exp_q[ch].size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check($sformatf("drain_ch%0d", ch), exp_q[ch].size(), 0);
    endtask

    initial begin
        int   b0;
        int   o0;
        logic [7:0] d;

        fork
            forever begin
                @(negedge clk);
                tick = ~tick;
            end
            forever begin
                @(negedge clk);
                if (busy_w[0]) busy_total++;
                if (ovr_w[0]) ovr_total++;
                for (int c = 0; c < 3; c++) begin
                    if (valid_w[c] && ready_v[c]) begin
                        if (exp_q[c].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_out ch%0d: got dout %0h, required none",
                                     c, dout_w[c]);
                        end else begin
                            exp_t e;
                            e = exp_q[c].pop_front();
                            check($sformatf("dout_ch%0d", c), dout_w[c], e.data);
                            check($sformatf("frame_err_ch%0d", c), fe_w[c], e.fe);
                            check($sformatf("parity_err_ch%0d", c), pe_w[c], e.pe);
                        end
                    end
                end
            end
            begin
                #2ms;
                $display("FAIL watchdog: got timeout, required completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("reset_valid", valid_w, 3'b000);
        check("reset_busy", busy_w, 3'b000);
        check("reset_dout0", dout_w[0], 8'h00);
        check("reset_flags", {fe_w, pe_w, ovr_w}, 9'h000);
        rst = 1'b1;
        wait_ticks(4);

        // 1: plain 8N1 frame and busy length (~9.5 bits of 32 clks)
        b0 = busy_total;
        expect_frame(0, 8'h55, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b11);
        wait_ticks(16);
        check("busy_len_ok", ((busy_total - b0) >= 296) && ((busy_total - b0) <= 312), 1);
        wait_drain(0);

        // 2: 4-tick glitch is rejected, following frame is clean
        rx_v[0] = 1'b0;
        wait_ticks(4);
        rx_v[0] = 1'b1;
        wait_ticks(16);
        check("glitch_valid", valid_w[0], 1'b0);
        check("glitch_busy", busy_w[0], 1'b0);
        expect_frame(0, 8'hA3, 1'b0, 1'b0);
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0);

        // 3: bad stop bit flagged, next frame clean
        expect_frame(0, 8'h0F, 1'b1, 1'b0);
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1, 2'b00);
        wait_ticks(32);
        expect_frame(0, 8'h10, 1'b0, 1'b0);
        send_frame(0, 8'h10, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0);

        // 4: even parity, then odd parity with two stop bits
        expect_frame(1, 8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1, 2'b11);
        expect_frame(1, 8'h07, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1, 2'b11);
        wait_drain(1);
        expect_frame(2, 8'h07, 1'b0, 1'b0);
        send_frame(2, 8'h07, 1'b1, 1'b0, 2, 2'b11);
        expect_frame(2, 8'h07, 1'b0, 1'b1);
        send_frame(2, 8'h07, 1'b1, 1'b1, 2, 2'b11);
        expect_frame(2, 8'h80, 1'b1, 1'b0);
        send_frame(2, 8'h80, 1'b1, 1'b0, 2, 2'b01);
        wait_drain(2);

        // 5: overrun while the consumer stalls
        ready_v[0] = 1'b0;
        o0 = ovr_total;
        expect_frame(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11);
        wait_ticks(8);
        check("ovr_pulses", ovr_total - o0, 1);
        check("held_valid", valid_w[0], 1'b1);
        check("held_dout", dout_w[0], 8'h11);
        @(posedge clk);
        #1 ready_v[0] = 1'b1;
        @(posedge clk);
        #1 ready_v[0] = 1'b0;
        check("valid_dropped", valid_w[0], 1'b0);
        ready_v[0] = 1'b1;
        expect_frame(0, 8'h33, 1'b0, 1'b0);
        send_frame(0, 8'h33, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0);

        // 6: reset in data bit 4 with a frame held, then a clean frame
        ready_v[0] = 1'b0;
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 2'b11);
        wait_ticks(4);
        check("pre_rst_valid", valid_w[0], 1'b1);
        d = 8'hC3;
        rx_v[0] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx_v[0] = d[i];
            wait_ticks(16);
        end
        rx_v[0] = d[4];
        wait_ticks(8);
        rst = 1'b0;
        #1;
        check("rst_valid", valid_w[0], 1'b0);
        check("rst_dout", dout_w[0], 8'h00);
        check("rst_flags", {fe_w[0], pe_w[0], ovr_w[0], busy_w[0]}, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        rx_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        rst = 1'b1;
        wait_ticks(32);
        check("post_rst_valid", valid_w[0], 1'b0);
        expect_frame(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0);
        wait_ticks(8);

        for (int c = 0; c < 3; c++) begin
            check($sformatf("final_queue_ch%0d", c), exp_q[c].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, oversampled UART receiver. Supports configurable data width, parity mode, stop-bit count and oversampling ratio. Adds start-bit glitch rejection, framing and parity error flags, and a valid/ready output register with overrun detection. Sits between the pad-level rx line and a byte consumer (FIFO or bus bridge), driven by the shared baud tick generator.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, ticks per bit period, even, legal 8..32
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, legal 1 or 2
SYNC_STAGES, 2, rx synchroniser depth, legal >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
rx  in  1  asynchronous serial input, idle high
tick  in  1  one-clk pulse at OVERSAMPLE x baud; all bit timing advances only on tick
dout  out  DATA_BITS  received payload
dout_valid  out  1  dout and error flags hold a frame
dout_ready  in  1  consumer accepts the frame when high with dout_valid
frame_err  out  1  any checked stop bit sampled 0; qualified by dout_valid
parity_err  out  1  parity mismatch, always 0 when PARITY_MODE = 0; qualified by dout_valid
overrun  out  1  one-clk pulse when a completed frame is dropped
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; tick counter, bit index, shift register and dout are 0.
  - dout_valid, frame_err, parity_err and overrun are 0.
  - Synchroniser flops are set to 1.
- Synchroniser: rx passes through SYNC_STAGES flops every clk, independent of tick. The result is rx_s, and all sampling uses rx_s.
- State and counter updates happen only on clk edges where tick = 1. Handshake and overrun logic run every clk.
- IDLE: on a tick with rx_s = 0, go to START and clear the counter.
- START: the counter increments each tick. When the counter reaches OVERSAMPLE/2 - 1, sample rx_s:
  - rx_s = 1 is a glitch: return to IDLE, with no output and no flags.
  - rx_s = 0: clear the counter and go to DATA. This sample point is the start-bit midpoint.
- DATA: when the counter reaches OVERSAMPLE - 1 (a bit midpoint), shift rx_s in LSB first and clear the counter. After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else go to STOP.
- PARITY: sample at the midpoint.
  - Even mode: error if the XOR of data bits and the parity bit is 1.
  - Odd mode: error if that XOR is 0.
  - Then go to STOP.
- STOP: sample STOP_BITS midpoints. Any 0 sets the internal frame error. On the last stop sample, the frame completes and the state returns to IDLE on the same tick, so a start edge in the remaining half stop bit is detected.
- Frame completion, on the same clk edge as the last stop sample:
  - If dout_valid = 0, or (dout_valid = 1 and dout_ready = 1): load dout, frame_err and parity_err, and set dout_valid = 1.
  - Otherwise, drop the new frame, keep the held frame unchanged, and pulse overrun = 1 for exactly one clk.
- Latency: dout_valid is visible the clk after the tick that sampled the last stop bit.
- Handshake:
  - dout_valid stays high and dout/flags stay stable until a clk with dout_ready = 1.
  - On that clk dout_valid clears, unless a new frame completes in the same clk, in which case the new frame loads and dout_valid stays 1.
  - dout_ready with dout_valid = 0 has no effect.
- Frames with frame_err (including break, all zeros) are still delivered.
- Reset mid-frame aborts the frame silently. The first frame after reset is received normally.
- tick held 0 freezes the receiver; no timeouts.

Test Plan:
(Defaults unless stated: OVERSAMPLE 16, DATA_BITS 8, PARITY_MODE 0, STOP_BITS 1, dout_ready = 1.)
1. Send 0x55, 8N1, ideal timing -> one dout_valid with dout = 0x55, frame_err = 0, parity_err = 0, busy high for about 9.5 bit periods.
2. Drive rx low for 4 ticks then high, then send 0xA3 -> no output for the glitch; the next output is 0xA3 with no flags.
3. Send 0x0F with the stop bit driven 0 -> dout = 0x0F, frame_err = 1; a following 0x10 with a good stop bit is received with frame_err = 0.
4. PARITY_MODE = 1: send 0x07 with parity bit 1 -> parity_err = 0; send 0x07 with parity bit 0 -> parity_err = 1. PARITY_MODE = 2, STOP_BITS = 2: send 0x07 with parity bit 0 -> parity_err = 0.
5. dout_ready = 0; send 0x11 then 0x22 back-to-back -> dout stays 0x11 and overrun pulses exactly once. Raise dout_ready for 1 clk -> dout_valid drops. Send 0x33 -> received cleanly.
6. Assert rst low for 3 clk during data bit 4 of a frame -> all outputs 0 immediately; after release, send 0x3C -> dout = 0x3C, no flags, no spurious valid from the aborted frame.
